// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV32I core.
//   Drives fetch-stage enables (pc_write, pc_control, IF_flush, IF_ID_write),
//   the ID/EX bubble and the back-end hold. It sequences post-reset warm-up,
//   load-use / branch-operand stalls and data-memory freeze.
//   Also keeps saturating stall / flush / memory-wait counters.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   ID_*                  operand usage and branch info of the IF/ID instruction
//   ID_EX_*               write/load/rd info of the instruction in EX
//   mem_busy              data memory not ready; back end must hold
//   pc_write .. EX_MEM_hold  Mealy control outputs, valid in the same cycle
//   *_count               CNT_W-bit saturating event counters
// Latency: outputs are combinational from state and inputs; counters lag by one edge.
// Backpressure: mem_busy freezes the whole pipe and holds the current state.

module hazard_ctrl #(
  parameter int STARTUP_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             ID_is_branch,
  input  logic             ID_branch_taken,
  input  logic             ID_EX_reg_write,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       ID_EX_rd,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_control,
  output logic             IF_flush,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_count
);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALL2  = 2'd2
  } state_t;

  localparam logic [3:0]       WARM_INIT = 4'(STARTUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       warm_q, warm_d;
  logic [CNT_W-1:0] stall_q, flush_q, memwait_q;

  // Event strobes feeding the performance counters.
  logic stall_inc, flush_inc, memwait_inc;

  // Hazard detection against the instruction currently in EX.
  // x0 is never a real producer, so rd==0 never creates a dependency.
  logic rs1_hit, rs2_hit, hit;
  logic load_use, br_alu, br_load, br_taken;

  assign rs1_hit  = ID_rs1_used && (ID_EX_rd != 5'd0) && (ID_EX_rd == ID_rs1);
  assign rs2_hit  = ID_rs2_used && (ID_EX_rd != 5'd0) && (ID_EX_rd == ID_rs2);
  assign hit      = rs1_hit || rs2_hit;
  assign load_use = ID_EX_mem_read && hit;
  // A branch compares in ID, so an ALU result in EX cannot be forwarded in time.
  assign br_alu   = ID_is_branch && ID_EX_reg_write && !ID_EX_mem_read && hit;
  // A branch on a load needs the value out of MEM/WB: two bubbles.
  assign br_load  = ID_is_branch && load_use;
  assign br_taken = ID_is_branch && ID_branch_taken;

  // Output decode and next state, highest priority first.
  always_comb begin
    pc_write     = 1'b0;
    pc_control   = 1'b0;
    IF_flush     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_MEM_hold  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    memwait_inc  = 1'b0;
    state_d      = state_q;
    warm_d       = warm_q;

    case (state_q)
      ST_STARTUP: begin
        // Fetch held and the front end kept empty; mem_busy is irrelevant here.
        IF_flush     = 1'b1;
        ID_EX_bubble = 1'b1;
        if (warm_q <= 4'd1) begin
          state_d = ST_RUN;
        end else begin
          warm_d = warm_q - 4'd1;
        end
      end

      ST_RUN, ST_STALL2: begin
        if (mem_busy) begin
          // Whole-pipe freeze: nothing moves and the state is retained, so a
          // pending second stall cycle resumes once memory is ready.
          EX_MEM_hold = 1'b1;
          memwait_inc = 1'b1;
        end else if (state_q == ST_STALL2) begin
          // Second bubble of a branch-on-load; branch outcome is not yet valid.
          ID_EX_bubble = 1'b1;
          stall_inc    = 1'b1;
          state_d      = ST_RUN;
        end else if (load_use || br_alu) begin
          // Stall beats a taken branch; the branch re-evaluates afterwards.
          ID_EX_bubble = 1'b1;
          stall_inc    = 1'b1;
          if (br_load) begin
            state_d = ST_STALL2;
          end
        end else if (br_taken) begin
          pc_control  = 1'b1;
          pc_write    = 1'b1;
          IF_flush    = 1'b1;
          IF_ID_write = 1'b1;
          flush_inc   = 1'b1;
        end else begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
      end

      default: begin
        // Unused encoding: behave like reset and restart the warm-up.
        IF_flush     = 1'b1;
        ID_EX_bubble = 1'b1;
        state_d      = ST_STARTUP;
        warm_d       = WARM_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_STARTUP;
      warm_q    <= WARM_INIT;
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      // Counters stick at all-ones rather than wrapping.
      if (stall_inc && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (flush_inc && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_ONE;
      end
      if (memwait_inc && (memwait_q != CNT_MAX)) begin
        memwait_q <= memwait_q + CNT_ONE;
      end
    end
  end

  assign stall_count   = stall_q;
  assign flush_count   = flush_q;
  assign memwait_count = memwait_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model. A second instance with 4-bit
// counters shares all inputs to exercise counter saturation.
module tb_hazard_ctrl;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] ID_rs1, ID_rs2, ID_EX_rd;
  logic       ID_rs1_used, ID_rs2_used, ID_is_branch, ID_branch_taken;
  logic       ID_EX_reg_write, ID_EX_mem_read, mem_busy;

  logic        pc_write, pc_control, IF_flush, IF_ID_write, ID_EX_bubble, EX_MEM_hold;
  logic [31:0] stall_count, flush_count, memwait_count;
  logic        s_pc_write, s_pc_control, s_IF_flush, s_IF_ID_write, s_ID_EX_bubble, s_EX_MEM_hold;
  logic [3:0]  s_stall_count, s_flush_count, s_memwait_count;

  // {pc_write, pc_control, IF_flush, IF_ID_write, ID_EX_bubble, EX_MEM_hold}
  logic [5:0] outs;
  assign outs = {pc_write, pc_control, IF_flush, IF_ID_write, ID_EX_bubble, EX_MEM_hold};

  localparam logic [5:0] O_RESET  = 6'b001010;
  localparam logic [5:0] O_RUN    = 6'b100100;
  localparam logic [5:0] O_STALL  = 6'b000010;
  localparam logic [5:0] O_FREEZE = 6'b000001;
  localparam logic [5:0] O_BRANCH = 6'b111100;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.STARTUP_CYCLES(SC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_is_branch(ID_is_branch), .ID_branch_taken(ID_branch_taken),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rd(ID_EX_rd),
    .mem_busy(mem_busy),
    .pc_write(pc_write), .pc_control(pc_control), .IF_flush(IF_flush), .IF_ID_write(IF_ID_write),
    .ID_EX_bubble(ID_EX_bubble), .EX_MEM_hold(EX_MEM_hold),
    .stall_count(stall_count), .flush_count(flush_count), .memwait_count(memwait_count)
  );

  hazard_ctrl #(.STARTUP_CYCLES(SC), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_is_branch(ID_is_branch), .ID_branch_taken(ID_branch_taken),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rd(ID_EX_rd),
    .mem_busy(mem_busy),
    .pc_write(s_pc_write), .pc_control(s_pc_control), .IF_flush(s_IF_flush), .IF_ID_write(s_IF_ID_write),
    .ID_EX_bubble(s_ID_EX_bubble), .EX_MEM_hold(s_EX_MEM_hold),
    .stall_count(s_stall_count), .flush_count(s_flush_count), .memwait_count(s_memwait_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int  warm_left;   // remaining warm-up cycles
  bit  second_due;  // a second branch-on-load bubble is owed
  int  m_stall, m_flush, m_mem;

  function automatic bit depends(input int src, input bit used);
    int rd = int'(ID_EX_rd);
    return used && rd != 0 && rd == src;
  endfunction

  function automatic bit need_stall();
    bit dep = depends(int'(ID_rs1), ID_rs1_used) || depends(int'(ID_rs2), ID_rs2_used);
    if (ID_EX_mem_read && dep) return 1'b1;                   // load result not ready
    if (ID_is_branch && ID_EX_reg_write && dep) return 1'b1;  // branch compares in ID
    return 1'b0;
  endfunction

  function automatic int stall_len();
    bit dep = depends(int'(ID_rs1), ID_rs1_used) || depends(int'(ID_rs2), ID_rs2_used);
    if (ID_is_branch && ID_EX_mem_read && dep) return 2;
    return 1;
  endfunction

  function automatic logic [5:0] model_out();
    if (warm_left > 0) return O_RESET;
    if (mem_busy)      return O_FREEZE;
    if (second_due)    return O_STALL;
    if (need_stall())  return O_STALL;
    if (ID_is_branch && ID_branch_taken) return O_BRANCH;
    return O_RUN;
  endfunction

  task automatic model_reset();
    warm_left = SC; second_due = 0; m_stall = 0; m_flush = 0; m_mem = 0;
  endtask

  task automatic model_tick();
    if (warm_left > 0) warm_left--;
    else if (mem_busy) m_mem++;
    else if (second_due) begin second_due = 0; m_stall++; end
    else if (need_stall()) begin m_stall++; second_due = (stall_len() == 2); end
    else if (ID_is_branch && ID_branch_taken) m_flush++;
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    ID_rs1 = 0; ID_rs2 = 0; ID_rs1_used = 0; ID_rs2_used = 0;
    ID_is_branch = 0; ID_branch_taken = 0;
    ID_EX_reg_write = 0; ID_EX_mem_read = 0; ID_EX_rd = 0; mem_busy = 0;
  endtask

  // Pulse reset and walk through warm-up; returns on the negedge of the first RUN cycle.
  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1;
    @(negedge clk); reset = 0;
    repeat (SC) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); idle_inputs(); mem_busy = 1; reset = 1; #1;
    n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, O_RESET); end
    n_cmp++; if ({stall_count, flush_count, memwait_count} !== 96'd0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", stall_count, flush_count, memwait_count); end
    @(negedge clk); reset = 0;
    for (int c = 0; c < SC; c++) begin
      #1;
      n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL warmup_%0d: got %b want %b", c, outs, O_RESET); end
      @(negedge clk);
    end
    mem_busy = 0; #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL first_run: got %b want %b", outs, O_RUN); end
    n_cmp++; if ({stall_count, flush_count, memwait_count} !== 96'd0) begin
      n_bad++; $display("FAIL warmup_counts: got %0d/%0d/%0d want 0/0/0", stall_count, flush_count, memwait_count); end
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_mem_read = 1; ID_EX_reg_write = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_rs1_used = 1; #1;
    n_cmp++; if (outs !== O_STALL) begin n_bad++; $display("FAIL lu_stall: got %b want %b", outs, O_STALL); end
    @(negedge clk); ID_EX_mem_read = 0; ID_EX_reg_write = 0; ID_EX_rd = 0; #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL lu_release: got %b want %b", outs, O_RUN); end
    n_cmp++; if (stall_count !== 32'd1) begin n_bad++; $display("FAIL lu_count: got %0d want 1", stall_count); end
    // Load to x0 never creates a dependency.
    ID_EX_mem_read = 1; ID_EX_reg_write = 1; ID_EX_rd = 0; ID_rs1 = 0; #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL lu_x0: got %b want %b", outs, O_RUN); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (stall_count !== 32'd1) begin n_bad++; $display("FAIL lu_x0_count: got %0d want 1", stall_count); end
    // Branch on an ALU result: exactly one bubble.
    ID_is_branch = 1; ID_EX_reg_write = 1; ID_EX_rd = 9; ID_rs2 = 9; ID_rs2_used = 1; #1;
    n_cmp++; if (outs !== O_STALL) begin n_bad++; $display("FAIL bralu_stall: got %b want %b", outs, O_STALL); end
    @(negedge clk); ID_EX_reg_write = 0; ID_EX_rd = 0; #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL bralu_release: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_branch_load();
    do_reset();
    ID_is_branch = 1; ID_branch_taken = 1; ID_EX_mem_read = 1; ID_EX_reg_write = 1;
    ID_EX_rd = 7; ID_rs2 = 7; ID_rs2_used = 1; #1;
    n_cmp++; if (outs !== O_STALL) begin n_bad++; $display("FAIL brld_stall1: got %b want %b", outs, O_STALL); end
    @(negedge clk); ID_EX_mem_read = 0; ID_EX_reg_write = 0; ID_EX_rd = 0; #1;
    n_cmp++; if (outs !== O_STALL) begin n_bad++; $display("FAIL brld_stall2: got %b want %b", outs, O_STALL); end
    @(negedge clk); #1;
    n_cmp++; if (outs !== O_BRANCH) begin n_bad++; $display("FAIL brld_taken: got %b want %b", outs, O_BRANCH); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL brld_after: got %b want %b", outs, O_RUN); end
    n_cmp++; if (stall_count !== 32'd2 || flush_count !== 32'd1) begin
      n_bad++; $display("FAIL brld_counts: got stall %0d flush %0d want 2/1", stall_count, flush_count); end
  endtask

  task automatic test_freeze_stall2();
    do_reset();
    ID_is_branch = 1; ID_EX_mem_read = 1; ID_EX_reg_write = 1; ID_EX_rd = 3; ID_rs1 = 3; ID_rs1_used = 1; #1;
    n_cmp++; if (outs !== O_STALL) begin n_bad++; $display("FAIL frz_stall1: got %b want %b", outs, O_STALL); end
    @(negedge clk); ID_EX_mem_read = 0; ID_EX_reg_write = 0; ID_EX_rd = 0; mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (outs !== O_FREEZE) begin n_bad++; $display("FAIL frz_hold_%0d: got %b want %b", c, outs, O_FREEZE); end
      @(negedge clk);
    end
    mem_busy = 0; #1;
    n_cmp++; if (outs !== O_STALL) begin n_bad++; $display("FAIL frz_stall2: got %b want %b", outs, O_STALL); end
    @(negedge clk); #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL frz_resume: got %b want %b", outs, O_RUN); end
    n_cmp++; if (memwait_count !== 32'd3 || stall_count !== 32'd2) begin
      n_bad++; $display("FAIL frz_counts: got memwait %0d stall %0d want 3/2", memwait_count, stall_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    ID_is_branch = 1; ID_branch_taken = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_cmp++; if (outs !== O_BRANCH) begin n_bad++; $display("FAIL sat_branch_%0d: got %b want %b", c, outs, O_BRANCH); end
      @(negedge clk);
    end
    idle_inputs(); #1;
    n_cmp++; if (flush_count !== 32'd20) begin n_bad++; $display("FAIL sat_wide: got %0d want 20", flush_count); end
    n_cmp++; if (s_flush_count !== 4'd15) begin n_bad++; $display("FAIL sat_narrow: got %0d want 15", s_flush_count); end
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    mem_busy = 1; #1;
    n_cmp++; if (outs !== O_FREEZE) begin n_bad++; $display("FAIL rmf_freeze: got %b want %b", outs, O_FREEZE); end
    #2 reset = 1; #1;
    n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL rmf_async: got %b want %b", outs, O_RESET); end
    @(negedge clk); reset = 0;
    for (int c = 0; c < SC; c++) begin
      #1;
      n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL rmf_startup_%0d: got %b want %b", c, outs, O_RESET); end
      @(negedge clk);
    end
    mem_busy = 0; #1;
    n_cmp++; if (outs !== O_RUN) begin n_bad++; $display("FAIL rmf_run: got %b want %b", outs, O_RUN); end
    n_cmp++; if (memwait_count !== 32'd0) begin n_bad++; $display("FAIL rmf_count: got %0d want 0", memwait_count); end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    @(negedge clk); idle_inputs(); reset = 1;
    @(negedge clk); reset = 0; model_reset();
    for (int c = 0; c < 600; c++) begin
      ID_EX_rd        = 5'($urandom_range(0, 3));
      ID_rs1          = 5'($urandom_range(0, 3));
      ID_rs2          = 5'($urandom_range(0, 3));
      ID_rs1_used     = 1'($urandom_range(0, 1));
      ID_rs2_used     = 1'($urandom_range(0, 1));
      ID_is_branch    = 1'($urandom_range(0, 1));
      ID_branch_taken = 1'($urandom_range(0, 1));
      ID_EX_reg_write = 1'($urandom_range(0, 1));
      ID_EX_mem_read  = ID_EX_reg_write & 1'($urandom_range(0, 1));
      mem_busy        = ($urandom_range(0, 4) == 0);
      #1;
      exp = model_out();
      n_cmp++; if (outs !== exp) begin n_bad++; $display("FAIL rnd_outs_%0d: got %b want %b", c, outs, exp); end
      n_cmp++; if (stall_count !== 32'(m_stall) || flush_count !== 32'(m_flush) || memwait_count !== 32'(m_mem)) begin
        n_bad++; $display("FAIL rnd_counts_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                          stall_count, flush_count, memwait_count, m_stall, m_flush, m_mem); end
      n_cmp++; if (s_stall_count !== 4'(sat15(m_stall)) || s_flush_count !== 4'(sat15(m_flush)) ||
                   s_memwait_count !== 4'(sat15(m_mem))) begin
        n_bad++; $display("FAIL rnd_sat_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, s_stall_count,
                          s_flush_count, s_memwait_count, sat15(m_stall), sat15(m_flush), sat15(m_mem)); end
      model_tick();
      @(negedge clk);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_load();
    test_freeze_stall2();
    test_saturation();
    test_reset_mid_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It generates `pc_write`, `pc_control`, `IF_flush` and `IF_ID_write` for the fetch stage, and the ID/EX bubble and back-end hold controls. It sequences three activities: a post-reset fetch warm-up, load-use and branch-operand stalls (including a 2-cycle stall state), and whole-pipe freeze on data-memory wait. It also keeps saturating stall, flush and memory-wait counters for performance debug.

## Interface
Parameters:
- `STARTUP_CYCLES`, default 2: cycles fetch is held after reset release. Legal range 1..15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ID_rs1`, `ID_rs2`  in  5 each  source registers of the instruction in IF/ID.
- `ID_rs1_used`, `ID_rs2_used`  in  1 each  the ID instruction reads rs1 / rs2.
- `ID_is_branch`  in  1  the ID instruction is a branch, resolved in ID.
- `ID_branch_taken`  in  1  branch comparator result in ID.
- `ID_EX_reg_write`  in  1  the EX instruction writes rd.
- `ID_EX_mem_read`  in  1  the EX instruction is a load.
- `ID_EX_rd`  in  5  destination register of the EX instruction.
- `mem_busy`  in  1  data memory not ready; the MEM stage must hold.
- `pc_write`  out  1  PC register update enable.
- `pc_control`  out  1  selects `pc_branch` as next PC.
- `IF_flush`  out  1  clears IF/ID.
- `IF_ID_write`  out  1  IF/ID load enable.
- `ID_EX_bubble`  out  1  forces zero controls into ID/EX.
- `EX_MEM_hold`  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- `stall_count`, `flush_count`, `memwait_count`  out  `CNT_W` each  saturating event counters.

## Operation
- FSM states: STARTUP, RUN, STALL2. Registers: 2-bit state, 4-bit warm-up counter, three counters.
- Definitions:
  - `m(r, used) = used && ID_EX_rd != 0 && ID_EX_rd == r`
  - `hit = m(ID_rs1, ID_rs1_used) || m(ID_rs2, ID_rs2_used)`
  - `load_use = ID_EX_mem_read && hit`
  - `br_alu = ID_is_branch && ID_EX_reg_write && !ID_EX_mem_read && hit`
  - `br_load = ID_is_branch && load_use`
- Output priority is highest first; default for every output is 0.
  1. **STARTUP:** `IF_flush=1`, `ID_EX_bubble=1`, `pc_write=0`, `IF_ID_write=0`. The warm-up counter counts down from `STARTUP_CYCLES`. At 1, next state is RUN. `mem_busy` is ignored.
  2. **`mem_busy=1` in RUN or STALL2 (freeze):** `EX_MEM_hold=1`, `pc_write=0`, `IF_ID_write=0`, `ID_EX_bubble=0`, `IF_flush=0`. State holds. `memwait_count` increments.
  3. **STALL2:** `pc_write=0`, `IF_ID_write=0`, `ID_EX_bubble=1`. `ID_branch_taken` is ignored. Next state is RUN. `stall_count` increments.
  4. **RUN with `load_use` or `br_alu`:** same outputs as a stall. `br_load` goes to STALL2; otherwise state stays RUN. `stall_count` increments.
  5. **RUN with `ID_is_branch && ID_branch_taken`:** `pc_control=1`, `pc_write=1`, `IF_flush=1`, `IF_ID_write=1`. `flush_count` increments.
  6. **RUN otherwise:** `pc_write=1`, `IF_ID_write=1`.
- Effective stall lengths:
  - Branch on a load in EX: 2 cycles.
  - Branch on an ALU result in EX: 1 cycle.
  - Non-branch load-use: 1 cycle.
  - All other dependencies are covered by forwarding; no stall.
- A taken branch is acted on only in a cycle with no stall and no freeze.
- Counters saturate at all-ones and never wrap.

## Timing
- Outputs are combinational from current state and inputs, valid in the same cycle (Mealy).
- State, warm-up counter and perf counters update on the rising edge of `clk`.
- Asynchronous `reset` forces state=STARTUP, warm-up counter=`STARTUP_CYCLES`, all counters=0.
- Reset output values: `IF_flush=1`, `ID_EX_bubble=1`; all other outputs 0.
- Reset asserted mid-stall or mid-freeze abandons it immediately; there is no pending-state carry-over.
- After release, the first `pc_write=1` occurs exactly `STARTUP_CYCLES` edges later.
- `mem_busy` arriving during STALL2 holds STALL2. The second stall cycle completes after `mem_busy` drops.
- Stall and branch in the same cycle: the stall wins, and the branch is re-evaluated when the stall ends.

## Test plan
- **Reset release, `STARTUP_CYCLES=2`:** 2 cycles of `IF_flush=1`, `pc_write=0`, then `pc_write=1`, `IF_ID_write=1`; all counts 0.
- **Load-use:** `ID_EX_mem_read=1`, `ID_EX_rd=5`, `ID_rs1=5`, `ID_rs1_used=1`, no branch → exactly 1 stall cycle; `stall_count=1`. Repeat with `ID_EX_rd=0` → no stall.
- **Branch on load:** `ID_is_branch=1`, `ID_branch_taken=1`, load rd=7 matches rs2 → 2 stall cycles, then `pc_control=1`, `IF_flush=1` for 1 cycle; `stall_count=2`, `flush_count=1`.
- **Freeze in STALL2:** raise `mem_busy` for 3 cycles during the second stall → `EX_MEM_hold=1` for 3 cycles, then 1 more stall cycle; `memwait_count=3`.
- **Saturation:** with `CNT_W=4`, 20 taken branches → `flush_count=15`.
- **Reset mid-freeze:** assert `reset` while `mem_busy=1` → outputs take reset values without waiting for a clock; state returns to STARTUP.
